// File: rtl/tinyriscv_pkg.sv
// rtl/tinyriscv_pkg.sv - shared RAM bus types and default RAM map constants
package tinyriscv_pkg;

  localparam int          RamDataWidth = 32;
  localparam int          RamAddrWidth = 32;
  localparam int          RamDepth     = 4096;
  localparam logic [31:0] RamBaseAddr  = 32'h1000_0000;

  typedef struct packed {
    logic                      we;
    logic [RamDataWidth/8-1:0] be;
    logic [RamAddrWidth-1:0]   addr;
    logic [RamDataWidth-1:0]   wdata;
  } ram_req_t;

  typedef struct packed {
    logic [RamDataWidth-1:0] rdata;
    logic                    err;
  } ram_rsp_t;

endpackage

// File: rtl/ram_array.sv
// rtl/ram_array.sv - byte-enabled sync-write/sync-read word storage (BRAM-swappable)
module ram_array #(
  parameter int DataWidth = 32,
  parameter int Depth     = 4096
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [DataWidth/8-1:0]   be_i,
  input  logic [$clog2(Depth)-1:0] idx_i,
  input  logic [DataWidth-1:0]     wdata_i,
  output logic [DataWidth-1:0]     rdata_o
);

  localparam int NumBytes = DataWidth / 8;

  logic [DataWidth-1:0] mem [Depth];

  // Read register only loads on a read, so a later write cannot disturb held data.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int k = 0; k < NumBytes; k++) begin
          if (be_i[k]) mem[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end else begin
        rdata_o <= mem[idx_i];
      end
    end
  end

endmodule

// File: rtl/ram_pipe.sv
// rtl/ram_pipe.sv - data RAM slave: decode, range/alignment errors, response pipeline
module ram_pipe
  import tinyriscv_pkg::*;
#(
  parameter int                   DataWidth   = RamDataWidth,
  parameter int                   AddrWidth   = RamAddrWidth,
  parameter int                   Depth       = RamDepth,
  parameter int                   ReadLatency = 1,
  parameter logic [AddrWidth-1:0] BaseAddr    = RamBaseAddr
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic                   gnt_o,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   err_o
);

  localparam int NumBytes = DataWidth / 8;
  localparam int IdxWidth = $clog2(Depth);

  logic                 accept;
  logic                 below_base, misaligned, out_of_range, addr_err;
  logic [AddrWidth-1:0] offset, word;
  logic [DataWidth-1:0] array_rdata;
  logic                 valid1, err1, read1;
  logic [DataWidth-1:0] rdata1;

  assign gnt_o  = req_i & ~rst_i;
  assign accept = req_i & gnt_o;

  assign offset       = addr_i - BaseAddr;
  assign word         = offset >> $clog2(NumBytes);
  assign below_base   = addr_i < BaseAddr;
  assign misaligned   = (offset & AddrWidth'(NumBytes - 1)) != '0;
  assign out_of_range = word >= AddrWidth'(Depth);
  assign addr_err     = below_base | misaligned | out_of_range;

  ram_array #(
    .DataWidth(DataWidth),
    .Depth    (Depth)
  ) u_array (
    .clk_i  (clk_i),
    .en_i   (accept & ~addr_err),
    .we_i   (we_i),
    .be_i   (be_i),
    .idx_i  (word[IdxWidth-1:0]),
    .wdata_i(wdata_i),
    .rdata_o(array_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid1 <= 1'b0;
      err1   <= 1'b0;
      read1  <= 1'b0;
    end else begin
      valid1 <= accept;
      err1   <= accept & addr_err;
      read1  <= accept & ~addr_err & ~we_i;
    end
  end

  // The array output is unreset and stale after writes; only a good read exposes it.
  assign rdata1 = read1 ? array_rdata : '0;

  generate
    if (ReadLatency == 1) begin : g_rl1
      assign rvalid_o = valid1;
      assign rdata_o  = rdata1;
      assign err_o    = err1;
    end else begin : g_rl2
      logic                 valid2, err2;
      logic [DataWidth-1:0] rdata2;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          valid2 <= 1'b0;
          err2   <= 1'b0;
          rdata2 <= '0;
        end else begin
          valid2 <= valid1;
          err2   <= err1;
          rdata2 <= rdata1;
        end
      end

      assign rvalid_o = valid2;
      assign rdata_o  = rdata2;
      assign err_o    = err2;
    end
  endgenerate

endmodule

// File: tb/tb_ram_pipe.sv
// tb/tb_ram_pipe.sv - self-checking bench running latency-1 and latency-2 RAMs side by side
module tb_ram_pipe;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] addr = '0, wdata = '0;
  logic        gnt1, gnt2, rv1, rv2, er1, er2;
  logic [31:0] rd1, rd2;

  always #5 clk = ~clk;

  ram_pipe #(.DataWidth(32), .AddrWidth(32), .Depth(DEPTH), .ReadLatency(1), .BaseAddr(BASE)) u_rl1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1), .err_o(er1));

  ram_pipe #(.DataWidth(32), .AddrWidth(32), .Depth(DEPTH), .ReadLatency(2), .BaseAddr(BASE)) u_rl2 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt2), .rvalid_o(rv2), .rdata_o(rd2), .err_o(er2));

  int n_pass = 0, n_chk = 0, cyc = 0, idx;

  // Model: word memory plus a list of accepted requests with the response each must give.
  logic [31:0] mem [DEPTH];
  typedef struct { int acc; logic [31:0] rdata; logic err; } exp_t;
  exp_t q[$];
  logic [31:0] last_rd [2];
  logic        last_er [2];

  function automatic logic bad_addr(input logic [31:0] a);
    return (a < BASE) || (((a - BASE) % 4) != 0) || (((a - BASE) / 4) >= DEPTH);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (req && !rst) begin
      e.acc   = cyc;
      e.err   = bad_addr(addr);
      e.rdata = '0;
      if (!e.err) begin
        idx = int'((addr - BASE) / 4);
        if (we) begin
          for (int k = 0; k < 4; k++) if (be[k]) mem[idx][8*k +: 8] = wdata[8*k +: 8];
        end else begin
          e.rdata = mem[idx];
        end
      end
      q.push_back(e);
    end
  end

  always @(posedge rst) q.delete();

  task automatic lane(input int l, input logic rv, input logic [31:0] rdv, input logic erv);
    bit   found = 0;
    exp_t e;
    foreach (q[i]) if (q[i].acc == cyc - l) begin found = 1; e = q[i]; end
    check($sformatf("rvalid_rl%0d", l + 1), rv, found);
    if (found && rv) begin
      check($sformatf("rdata_rl%0d", l + 1), rdv, e.rdata);
      check($sformatf("err_rl%0d", l + 1), erv, e.err);
    end
    if (rv) begin last_rd[l] = rdv; last_er[l] = erv; end
  endtask

  always begin
    @(negedge clk);
    #1;
    check("gnt_rl1", gnt1, req & ~rst);
    check("gnt_rl2", gnt2, req & ~rst);
    lane(0, rv1, rd1, er1);
    lane(1, rv2, rd2, er2);
    while (q.size() > 0 && q[0].acc < cyc - 1) void'(q.pop_front());
  end

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = 1'b0; we = 1'b0; be = 4'h0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] wa(input int i);
    return BASE + 32'(4 * i);
  endfunction

  task automatic pin(input string name, input logic [31:0] exp);
    check({name, "_rl1"}, last_rd[0], exp);
    check({name, "_rl2"}, last_rd[1], exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_rvalid", {rv1, rv2}, 2'b00);
    check("reset_rdata_rl1", rd1, 32'h0);
    check("reset_rdata_rl2", rd2, 32'h0);
    check("reset_err", {er1, er2}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b1, 4'hF, wa(3), 32'hAABB_CCDD);
    issue(1'b1, 4'b0101, wa(3), 32'h1122_3344);
    issue(1'b0, 4'h0, wa(3), 32'h0);
    idle(3);
    pin("byte_strobe", 32'hAA22_CC44);

    issue(1'b1, 4'hF, wa(4), 32'h0000_0010);
    issue(1'b0, 4'h0, wa(4), 32'h0);
    idle(3);
    pin("raw_next_cycle", 32'h0000_0010);

    for (int i = 8; i < 16; i++) issue(1'b1, 4'hF, wa(i), 32'hC0DE_0000 + 32'(i));
    for (int i = 8; i < 16; i++) issue(1'b0, 4'h0, wa(i), 32'h0);
    idle(3);
    pin("burst_last", 32'hC0DE_000F);

    issue(1'b1, 4'hF, wa(0), 32'h0123_4567);
    issue(1'b1, 4'hF, wa(DEPTH - 1), 32'h89AB_CDEF);
    issue(1'b0, 4'h0, wa(0), 32'h0);
    issue(1'b0, 4'h0, wa(DEPTH - 1), 32'h0);
    idle(3);
    pin("last_word", 32'h89AB_CDEF);
    check("last_word_err", {last_er[0], last_er[1]}, 2'b00);

    issue(1'b1, 4'hF, BASE + 32'd2, 32'hDEAD_BEEF);
    issue(1'b0, 4'h0, wa(0), 32'h0);
    issue(1'b0, 4'h0, BASE + 32'(4 * DEPTH), 32'h0);
    issue(1'b0, 4'h0, BASE - 32'd4, 32'h0);
    idle(3);
    pin("err_rdata", 32'h0);
    check("err_flag", {last_er[0], last_er[1]}, 2'b11);

    issue(1'b0, 4'h0, wa(5), 32'h0);
    issue(1'b0, 4'h0, wa(4), 32'h0);
    issue(1'b1, 4'hF, wa(4), 32'h5555_5555);
    issue(1'b1, 4'h0, wa(4), 32'hFFFF_FFFF);
    issue(1'b0, 4'h0, wa(4), 32'h0);
    idle(3);
    pin("noop_write", 32'h5555_5555);

    issue(1'b0, 4'h0, wa(8), 32'h0);
    req = 1'b1; we = 1'b0; addr = wa(9);
    #2 rst = 1'b1;
    req = 1'b0;
    #1 check("async_reset_rvalid", {rv1, rv2}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 4'h0, BASE, 32'h0);
    idle(3);
    pin("after_reset", 32'h0123_4567);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
